// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/freeze controller: FSM state
// encoding, the x0 register index and the load-use hazard equation.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A load in EX blocks the ID instruction only through a register it actually reads.
  function automatic logic load_use_hazard(
    input logic       ex_load,
    input logic [4:0] ex_dest,
    input logic       uses1,
    input logic [4:0] rs1,
    input logic       uses2,
    input logic [4:0] rs2
  );
    return ex_load && (ex_dest != REG_X0) &&
           ((uses1 && (rs1 == ex_dest)) || (uses2 && (rs2 == ex_dest)));
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for each pipeline performance counter; it holds
// at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments and an asynchronous reset in the sensitivity list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use stall/bubble, branch flush, data-memory freeze
// with timeout to a sticky ERROR state. Define PIPE_PERF_CNT_EN to add the
// luCnt/waitCnt/flushCnt saturating performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       idRs1_pi,
  input  logic [4:0]       idRs2_pi,
  input  logic             idUses1_pi,
  input  logic             idUses2_pi,
  input  logic [4:0]       exDest_pi,
  input  logic             exLoad_pi,
  input  logic             branchTaken_pi,
  input  logic             dmemReq_pi,
  input  logic             dmemReady_pi,
  output logic             stallIF_po,
  output logic             stallID_po,
  output logic             bubbleEX_po,
  output logic             flushID_po,
  output logic             flushEX_po,
  output logic             freeze_po,
  output logic             error_po,
  output logic [1:0]       state_po
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] luCnt_po,
  output logic [CNT_W-1:0] waitCnt_po,
  output logic [CNT_W-1:0] flushCnt_po
`endif
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_stall;
  logic              lu_haz;
  logic              freeze;

  always_comb begin
    mem_stall = dmemReq_pi & ~dmemReady_pi;
    lu_haz    = load_use_hazard(exLoad_pi, exDest_pi, idUses1_pi, idRs1_pi,
                                idUses2_pi, idRs2_pi);
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    unique case (state_q)
      RUN: begin
        freeze     = mem_stall;
        wait_cnt_d = '0;
        if (mem_stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        freeze = mem_stall;
        if (!mem_stall)                    state_d = RUN;
        else if (wait_cnt_q == WAIT_LAST)  state_d = ERROR;
        else                               wait_cnt_d = wait_cnt_q + 1'b1;
      end
      ERROR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Priority: freeze > branch flush > load-use; everything is quiet while reset is held.
  always_comb begin
    freeze_po   = freeze & ~reset;
    flushID_po  = branchTaken_pi & ~freeze & ~reset;
    flushEX_po  = flushID_po;
    stallIF_po  = lu_haz & ~branchTaken_pi & ~freeze & ~reset;
    stallID_po  = stallIF_po;
    bubbleEX_po = stallIF_po;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign error_po = (state_q == ERROR);
  assign state_po = state_q;

`ifdef PIPE_PERF_CNT_EN
  sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubbleEX_po),
    .count (luCnt_po)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (freeze_po),
    .count (waitCnt_po)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flushEX_po),
    .count (flushCnt_po)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of single-cycle hazard vectors plus
// hand-written memory-wait, frozen-branch, timeout and reset sequences.
module tb_pipe_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    idRs1_pi, idRs2_pi, exDest_pi;
  logic          idUses1_pi, idUses2_pi, exLoad_pi;
  logic          branchTaken_pi, dmemReq_pi, dmemReady_pi;
  logic          stallIF_po, stallID_po, bubbleEX_po;
  logic          flushID_po, flushEX_po, freeze_po, error_po;
  logic [1:0]    state_po;
`ifdef PIPE_PERF_CNT_EN
  logic [CW-1:0] luCnt_po, waitCnt_po, flushCnt_po;
`endif

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .idRs1_pi       (idRs1_pi),
    .idRs2_pi       (idRs2_pi),
    .idUses1_pi     (idUses1_pi),
    .idUses2_pi     (idUses2_pi),
    .exDest_pi      (exDest_pi),
    .exLoad_pi      (exLoad_pi),
    .branchTaken_pi (branchTaken_pi),
    .dmemReq_pi     (dmemReq_pi),
    .dmemReady_pi   (dmemReady_pi),
    .stallIF_po     (stallIF_po),
    .stallID_po     (stallID_po),
    .bubbleEX_po    (bubbleEX_po),
    .flushID_po     (flushID_po),
    .flushEX_po     (flushEX_po),
    .freeze_po      (freeze_po),
    .error_po       (error_po),
    .state_po       (state_po)
`ifdef PIPE_PERF_CNT_EN
    ,
    .luCnt_po       (luCnt_po),
    .waitCnt_po     (waitCnt_po),
    .flushCnt_po    (flushCnt_po)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] dest;
    logic       ld, br, req, rdy;
    logic [5:0] exp;  // {stallIF, stallID, bubbleEX, flushID, flushEX, freeze}
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input string n, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] dest,
                              input logic ld, input logic br, input logic req,
                              input logic rdy, input logic [5:0] exp);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.dest = dest;
    v.ld = ld; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    idRs1_pi = v.rs1; idRs2_pi = v.rs2; idUses1_pi = v.u1; idUses2_pi = v.u2;
    exDest_pi = v.dest; exLoad_pi = v.ld; branchTaken_pi = v.br;
    dmemReq_pi = v.req; dmemReady_pi = v.rdy;
  endtask

  function automatic logic [5:0] obs();
    return {stallIF_po, stallID_po, bubbleEX_po, flushID_po, flushEX_po, freeze_po};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    apply(mk("idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0));
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  vec_t idle, haz, haz_br;

  initial begin
    idle   = mk("idle",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000);
    haz    = mk("haz",    5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111000);
    haz_br = mk("haz_br", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000110);

    vecs[0]  = idle;
    vecs[1]  = haz;
    vecs[2]  = mk("x0_dest",   5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 6'b000000);
    vecs[3]  = mk("rs2_match", 5'd3,  5'd7,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 6'b111000);
    vecs[4]  = mk("not_used",  5'd5,  5'd5,  1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 6'b000000);
    vecs[5]  = mk("not_load",  5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 6'b000000);
    vecs[6]  = haz_br;
    vecs[7]  = mk("br_only",   5'd1,  5'd2,  1'b0, 1'b0, 5'd9,  1'b0, 1'b1, 1'b0, 1'b0, 6'b000110);
    vecs[8]  = mk("mem_ready", 5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 6'b111000);
    vecs[9]  = mk("x31",       5'd4,  5'd31, 1'b0, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111000);
    vecs[10] = mk("x0_rs2",    5'd6,  5'd0,  1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 6'b000000);

    // Reset state, with quiet inputs
    reset = 1'b1;
    apply(idle);
    #1;
    check("reset_outs",  {26'b0, obs()}, 32'd0);
    check("reset_state", {30'b0, state_po}, 32'd0);
    check("reset_error", {31'b0, error_po}, 32'd0);
`ifdef PIPE_PERF_CNT_EN
    check("reset_cnts", {20'b0, luCnt_po, waitCnt_po, flushCnt_po}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Single-cycle vectors, all in RUN
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check({"vec_", vecs[i].name}, {26'b0, obs()}, {26'b0, vecs[i].exp});
      check({"vec_state_", vecs[i].name}, {30'b0, state_po}, 32'd0);
    end

    // Memory wait: 3 frozen cycles, then ready
    do_reset();
    @(negedge clk);
    apply(mk("mw", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b0));
    #1;
    check("mw_c0_freeze", {31'b0, freeze_po}, 32'd1);
    check("mw_c0_state",  {30'b0, state_po},  32'd0);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); #1;
      check($sformatf("mw_c%0d_freeze", i), {31'b0, freeze_po}, 32'd1);
      check($sformatf("mw_c%0d_state", i),  {30'b0, state_po},  32'd1);
    end
    @(negedge clk);
    dmemReady_pi = 1'b1;
    #1;
    check("mw_ready_freeze", {31'b0, freeze_po}, 32'd0);
    check("mw_ready_state",  {30'b0, state_po},  32'd1);
    @(negedge clk);
    apply(idle);
    #1;
    check("mw_back_state", {30'b0, state_po}, 32'd0);
`ifdef PIPE_PERF_CNT_EN
    check("mw_waitcnt", {28'b0, waitCnt_po}, 32'd3);
`endif

    // Branch held through a 2-cycle freeze, with a load-use hazard also present
    do_reset();
    @(negedge clk);
    apply(haz_br);
    dmemReq_pi = 1'b1;
    #1;
    check("fb_c0_outs", {26'b0, obs()}, 32'b000001);
    @(negedge clk); #1;
    check("fb_c1_outs",  {26'b0, obs()},    32'b000001);
    check("fb_c1_state", {30'b0, state_po}, 32'd1);
    @(negedge clk);
    dmemReady_pi = 1'b1;
    #1;
    check("fb_unfrozen_outs", {26'b0, obs()}, 32'b000110);
    @(negedge clk);
    apply(idle);
    #1;
    check("fb_after_outs",  {26'b0, obs()},    32'd0);
    check("fb_after_state", {30'b0, state_po}, 32'd0);
`ifdef PIPE_PERF_CNT_EN
    check("fb_flushcnt", {28'b0, flushCnt_po}, 32'd1);
    check("fb_lucnt",    {28'b0, luCnt_po},    32'd0);
    check("fb_waitcnt",  {28'b0, waitCnt_po},  32'd2);
`endif

    // Timeout: ready never arrives
    do_reset();
    @(negedge clk);
    apply(mk("to", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b0));
    #1;
    check("to_c0_state", {30'b0, state_po}, 32'd0);
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk); #1;
      check($sformatf("to_wait%0d_state", i), {30'b0, state_po}, 32'd1);
      check($sformatf("to_wait%0d_error", i), {31'b0, error_po}, 32'd0);
    end
    @(negedge clk); #1;
    check("to_err_state",  {30'b0, state_po},  32'd2);
    check("to_err_error",  {31'b0, error_po},  32'd1);
    check("to_err_freeze", {31'b0, freeze_po}, 32'd1);
    dmemReady_pi = 1'b1;
    branchTaken_pi = 1'b1;
    @(negedge clk); #1;
    check("to_sticky_state", {30'b0, state_po}, 32'd2);
    check("to_sticky_outs",  {26'b0, obs()},    32'b000001);
    // Asynchronous reset between clock edges
    apply(idle);
    reset = 1'b1;
    #1;
    check("to_areset_state", {30'b0, state_po}, 32'd0);
    check("to_areset_error", {31'b0, error_po}, 32'd0);
    check("to_areset_outs",  {26'b0, obs()},    32'd0);
    #1;
    reset = 1'b0;
    @(negedge clk); #1;
    check("to_post_state", {30'b0, state_po}, 32'd0);

`ifdef PIPE_PERF_CNT_EN
    // Saturation: 20 bubble cycles into a 4-bit counter
    do_reset();
    @(negedge clk);
    apply(haz);
    repeat (20) @(negedge clk);
    apply(idle);
    #1;
    check("sat_lucnt", {28'b0, luCnt_po}, 32'd15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum MEM_WAIT cycles before the ERROR state is entered.
REQ-002 Parameter CNT_W, default 32: width of each performance counter.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 idRs1_pi / idRs2_pi  in  5 each  source registers of the instruction in ID.
REQ-006 idUses1_pi / idUses2_pi  in  1 each  the ID instruction reads rs1 / rs2.
REQ-007 exDest_pi  in  5  EX-stage destination register.
REQ-008 exLoad_pi  in  1  the EX instruction is a load.
REQ-009 branchTaken_pi  in  1  EX resolved a taken branch or jump.
REQ-010 dmemReq_pi  in  1  MEM-stage data memory request.
REQ-011 dmemReady_pi  in  1  data memory completes the request this cycle.
REQ-012 stallIF_po / stallID_po  out  1 each  hold PC and the IF/ID register.
REQ-013 bubbleEX_po  out  1  load a NOP into ID/EX.
REQ-014 flushID_po / flushEX_po  out  1 each  squash IF/ID and ID/EX.
REQ-015 freeze_po  out  1  hold every pipeline register and insert a NOP into MEM/WB.
REQ-016 error_po  out  1  sticky memory timeout.
REQ-017 state_po  out  2  current FSM state.
REQ-018 luCnt_po / waitCnt_po / flushCnt_po  out  CNT_W each  performance counters; present only with PIPE_PERF_CNT_EN.

Function
REQ-019 The FSM SHALL have three states:
- RUN = 0
- MEM_WAIT = 1
- ERROR = 2
REQ-020 stall, bubble, flush and freeze outputs SHALL be combinational from the current state and inputs; state and counters SHALL be registered.
REQ-021 In RUN and MEM_WAIT, freeze_po SHALL equal dmemReq_pi & ~dmemReady_pi.
REQ-022 State transitions SHALL be:
- RUN -> MEM_WAIT when freeze_po = 1.
- MEM_WAIT -> RUN when dmemReady_pi = 1 or dmemReq_pi = 0; freeze_po is 0 in that same cycle.
REQ-023 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle.
REQ-024 When the wait counter equals TIMEOUT_CYCLES-1 with freeze still required, the FSM SHALL move to ERROR.
REQ-025 ERROR SHALL force freeze_po = 1 and error_po = 1 and SHALL be left only by reset.
REQ-026 Load-use hazard: luHaz = exLoad_pi & (exDest_pi != 0) & ((idUses1_pi & idRs1_pi == exDest_pi) | (idUses2_pi & idRs2_pi == exDest_pi)).
REQ-027 When luHaz is set and freeze_po and branchTaken_pi are both 0, stallIF_po, stallID_po and bubbleEX_po SHALL all be 1 for exactly that cycle.
REQ-028 When branchTaken_pi is set and freeze_po is 0, flushID_po and flushEX_po SHALL be 1 for one cycle, and the load-use outputs SHALL be 0.
REQ-029 Priority SHALL be freeze > branch flush > load-use; a branch held in EX during a freeze SHALL be acted on in the first unfrozen cycle.
REQ-030 Register x0 SHALL never cause a hazard.

Reset
REQ-031 Reset SHALL force:
- state RUN, wait counter 0, error_po 0, counters 0.
- all stall, bubble, flush and freeze outputs 0, evaluated combinationally from the reset state.
REQ-032 Reset asserted mid-MEM_WAIT or in ERROR SHALL return the block to RUN immediately, without waiting for a clock edge.

Configuration
REQ-033 With PIPE_PERF_CNT_EN defined, each counter SHALL saturate at all-ones:
- luCnt_po counts cycles in which bubbleEX_po = 1.
- waitCnt_po counts cycles in which freeze_po = 1.
- flushCnt_po counts cycles in which flushEX_po = 1.
REQ-034 Without PIPE_PERF_CNT_EN, the counter ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-035 A shared package SHALL hold the state encoding constants (RUN, MEM_WAIT, ERROR) and the x0 register constant.
REQ-036 One sub-module, sat_counter (parameter CNT_W; ports clk, reset, inc, count), SHALL implement each performance counter.

Verification
REQ-037 Load-use: exLoad=1, exDest=5, idRs1=5, idUses1=1 -> stallIF = stallID = bubbleEX = 1 for one cycle; with exDest=0 -> all 0.
REQ-038 Branch over load-use: branchTaken=1 together with the REQ-037 hazard -> flushID = flushEX = 1 and bubbleEX = 0.
REQ-039 Memory wait: dmemReq=1, dmemReady=0 for 3 cycles, then ready=1 -> freeze = 1 for 3 cycles, state 0 -> 1 -> 0, waitCnt_po = 3.
REQ-040 Timeout: TIMEOUT_CYCLES = 4, ready held at 0 -> state = 2 and error = 1 after 4 MEM_WAIT cycles; an asynchronous reset pulse clears both.
REQ-041 Frozen branch: branchTaken=1 during a 2-cycle freeze -> no flush while frozen; flushID = flushEX = 1 in the first unfrozen cycle; flushCnt_po = 1.
